// File: rtl/prng_sched.sv
// Round-robin scheduler that shares a seeded Fibonacci LFSR among N_REQ requesters.
// Optional words_served statistics counter is enabled by defining PRNG_SCHED_STATS_EN.
module prng_sched #(
    parameter int unsigned      N_REQ = 2,
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter int unsigned      WORD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    output logic             seed_ready,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] rsp_valid,
    output logic [WORD-1:0]  rsp_data,
    output logic [15:0]      words_served
);

    localparam int unsigned MAXB = (WIDTH > WORD) ? WIDTH : WORD;
    localparam int unsigned CW   = $clog2(MAXB + 1);
    localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEED, GEN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] seed_sh_q, seed_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [WORD-1:0]  rsp_data_q, rsp_data_d;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic             fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= WIDTH'(1);
            seed_sh_q  <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gidx_q     <= '0;
            grant_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_sh_q  <= seed_sh_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            grant_q    <= grant_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Rotating priority: first pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!win_found && req[i] && (PW'(i) >= ptr_q)) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seed_sh_d  = seed_sh_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        grant_d    = grant_q;
        rsp_data_d = rsp_data_q;
        fb         = ^(lfsr_q & TAPS);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (seed_load) begin
                    state_d   = SEED;
                    seed_sh_d = seed_value;
                end else if (win_found) begin
                    state_d = GEN;
                    gidx_d  = win_idx;
                    grant_d = N_REQ'(1) << win_idx;
                end
            end
            SEED: begin
                lfsr_d    = {seed_sh_q[0], lfsr_q[WIDTH-1:1]};
                seed_sh_d = seed_sh_q >> 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    if (lfsr_d == '0) lfsr_d = WIDTH'(1);
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GEN: begin
                lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
                for (int unsigned k = 0; k < WORD; k++) begin
                    if (cnt_q == CW'(k)) rsp_data_d[k] = lfsr_q[0];
                end
                if (cnt_q == CW'(WORD - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    ptr_d   = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seed_ready = (state_q == IDLE);
        rsp_valid  = (state_q == DONE) ? grant_q : '0;
        grant      = grant_q;
        rsp_data   = rsp_data_q;
    end

`ifdef PRNG_SCHED_STATS_EN
    logic [15:0] served_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            served_q <= '0;
        end else if ((state_q == DONE) && (served_q != '1)) begin
            served_q <= served_q + 16'd1;
        end
    end

    assign words_served = served_q;
`else
    assign words_served = '0;
`endif

endmodule

// File: doc/prng_sched.md
# prng_sched

Round-robin scheduler that owns a Fibonacci LFSR and shares it among `N_REQ` requesters. It loads the LFSR serially from a seed word and steps it `WORD` times per request. Each request is answered with one `WORD`-bit random word. The block sits between the random-bit datapath and its consumers, and is the only block allowed to step or seed the generator.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `WIDTH`, 8, LFSR state width (≥ 3)
- `TAPS`, 8'h1D, feedback mask. New MSB = XOR of `state & TAPS`; bit 0 must be set.
- `WORD`, 4, bits returned per grant (1..16)
- `clk` in 1: single clock; all state changes on its rising edge
- `rst` in 1: synchronous, active-high reset
- `seed_load` in 1: request to load `seed_value`; accepted only when `seed_ready`=1
- `seed_value` in `WIDTH`: new LFSR state
- `seed_ready` out 1: high in IDLE only
- `req` in `N_REQ`: per-requester request level; held until that requester's `rsp_valid`
- `grant` out `N_REQ`: one-hot, registered; high from GEN entry through DONE
- `rsp_valid` out `N_REQ`: one-hot, single-cycle pulse in DONE
- `rsp_data` out `WORD`: random word; valid when any `rsp_valid` bit is set; holds last word otherwise
- `words_served` out 16: stats counter (see Configuration)

## Operation
- LFSR step: `out_bit = state[0]`, then `state <= {fb, state[WIDTH-1:1]}`, where `fb = ^(state & TAPS)`.
- States:
  - **IDLE**
    - If `seed_load`=1 → SEED. Seed has priority over `req`.
    - Else if `|req` → GEN. The winner is latched as a one-hot `grant`.
    - Else stay in IDLE.
  - **SEED**, `WIDTH` cycles. Cycle i shifts `seed_value[i]` (latched at accept) into the MSB instead of `fb`. After `WIDTH` cycles, `state == seed_value`.
    - On the final cycle, if the result is all-zero, force `state = 1`.
    - Then → IDLE.
  - **GEN**, `WORD` cycles. Cycle k performs one step and stores `out_bit` into `rsp_data[k]` (LSB first). Then → DONE.
  - **DONE**, 1 cycle. `rsp_valid = grant`. Then → IDLE; `grant` clears on that edge.
- Arbitration: round-robin pointer `ptr`.
  - Winner = first set `req` bit searching from `ptr` upward, wrapping.
  - On entry to DONE, `ptr` = granted index + 1, modulo `N_REQ`.
- `req` deasserted during GEN: the transaction still completes and `rsp_valid` still pulses.
- `seed_load` outside IDLE is ignored (not queued).
- The LFSR steps only in SEED or GEN. There is no free-running.

## Timing
- Reset values:
  - state IDLE, LFSR `state = 1`, `ptr = 0`
  - `grant = 0`, `rsp_valid = 0`, `rsp_data = 0`, `seed_ready = 1`, `words_served = 0`
- Request latency: `req` sampled high in IDLE at cycle 0 → `grant` high at cycle 1 → `rsp_valid` at cycle `WORD+1` → back in IDLE at cycle `WORD+2`.
  - Back-to-back service: one word per `WORD+2` cycles.
- Seed latency: accepted at cycle 0 → `seed_ready` low in cycles 1..`WIDTH` → high at `WIDTH+1`.
- `rst` in any state aborts immediately to the reset values. No partial `rsp_valid` is emitted.
- Bit-count arithmetic: the SEED/GEN counter is `$clog2(max(WIDTH,WORD)+1)` bits, compares to the terminal value, and never wraps mid-state.

## Configuration
- `PRNG_SCHED_STATS_EN` defined:
  - `words_served` increments on every DONE cycle.
  - 16-bit, saturating at 16'hFFFF.
  - Cleared by `rst`.
- Not defined: `words_served` is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- Reset, then `req`=2'b01 with defaults → `grant`=01 at cycle 1, `rsp_valid`=01 at cycle 5 with `rsp_data`=4'h1. Second request → `rsp_data`=4'h0, LFSR `state`=8'h71.
- `seed_load` with `seed_value`=8'h00 → `seed_ready` low for 8 cycles. The next word equals the post-reset value 4'h1 (zero seed forced to 8'h01).
- `req`=2'b11 held continuously → grants alternate 01, 10, 01. Each grant lasts 5 cycles, and consecutive grants are 6 cycles apart.
- `seed_load` and `req` both high in IDLE → SEED is taken first. The grant follows at cycle `WIDTH+2`, and `seed_load` during GEN is ignored.
- `rst` asserted mid-GEN (cycle 2) → the next cycle shows all outputs at reset values and no `rsp_valid`. The following request returns 4'h1.
- With `PRNG_SCHED_STATS_EN`: 3 served requests → `words_served`=3. After `rst`, `words_served`=0.
